// File: rtl/aes_pkg.sv
// Shared constants and encodings for the AES-256 round-key schedule controller.
package aes_pkg;

  localparam int unsigned NR          = 14;
  localparam int unsigned CNT_LAST    = 6;
  localparam int unsigned RK_WIDTH    = 128;
  localparam int unsigned ROUND_WIDTH = 4;
  localparam int unsigned CNT_WIDTH   = 5;

  // Codes driven on exp_state_o to the expansion datapath
  localparam logic [3:0] EXP_IDLE   = 4'd0;
  localparam logic [3:0] EXP_ADD_RK = 4'd1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_DONE   = 2'd3
  } ks_state_e;

endpackage

// File: rtl/round_key_store.sv
// Round-key RAM: one write port, one registered read port, unreset data array.
module round_key_store
  import aes_pkg::*;
#(
  parameter int unsigned DEPTH  = NR + 1,
  parameter int unsigned WIDTH  = RK_WIDTH,
  parameter int unsigned ADDR_W = ROUND_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic              rzero_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Out-of-range reads return zero instead of touching the array
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rzero_i ? '0 : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/aes256_key_sched_ctrl.sv
// AES-256 key schedule controller: sequences the expansion datapath, stores
// the 15 round keys and serves indexed reads to the cipher core.
module aes256_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned KEY_WIDTH = 256,
  parameter int unsigned NR        = aes_pkg::NR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid_i,
  input  logic [KEY_WIDTH-1:0] key_i,
  output logic                 key_ready_o,
  input  logic                 flush_i,
  output logic [3:0]           exp_state_o,
  output logic [3:0]           exp_round_o,
  output logic [4:0]           exp_cnt_o,
  input  logic [127:0]         exp_rk_i,
  input  logic                 rk_req_i,
  input  logic [3:0]           rk_idx_i,
  output logic                 rk_valid_o,
  output logic [127:0]         rk_data_o,
  output logic                 rk_err_o,
  output logic                 busy_o,
  output logic                 keys_ready_o
);

  ks_state_e                  state_q, state_d;
  logic [ROUND_WIDTH-1:0]     round_q, round_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]       valid_cnt_q, valid_cnt_d;
  logic                       key_ready_q, busy_q, keys_ready_q;
  logic                       rk_valid_q, rk_err_q;
  logic [3:0]                 exp_state_q, exp_round_q;
  logic [CNT_WIDTH-1:0]       exp_cnt_q;
  logic                       wr_en_c, rd_en_c, rd_err_c;
  logic                       unused_key_c;

  // The datapath latches key_i itself; the controller only sequences it
  assign unused_key_c = ^key_i;

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    cnt_d       = cnt_q;
    valid_cnt_d = valid_cnt_q;
    wr_en_c     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (key_valid_i) begin
          state_d     = ST_LOAD;
          valid_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        state_d = ST_EXPAND;
        round_d = '0;
        cnt_d   = '0;
      end
      ST_EXPAND: begin
        if (cnt_q == CNT_WIDTH'(CNT_LAST)) begin
          wr_en_c     = 1'b1;
          valid_cnt_d = valid_cnt_q + 5'd1;
          cnt_d       = '0;
          if (round_q == ROUND_WIDTH'(NR)) begin
            state_d = ST_DONE;
            round_d = '0;
          end else begin
            round_d = round_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush wins over everything, including a same-cycle key offer or write
    if (flush_i) begin
      state_d     = ST_IDLE;
      round_d     = '0;
      cnt_d       = '0;
      valid_cnt_d = '0;
      wr_en_c     = 1'b0;
    end
  end

  // A read is served once its entry is stored, or immediately as an error
  assign rd_err_c = 32'(rk_idx_i) > NR;
  assign rd_en_c  = rk_req_i && !flush_i &&
                    (rd_err_c || ({1'b0, rk_idx_i} < valid_cnt_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      round_q      <= '0;
      cnt_q        <= '0;
      valid_cnt_q  <= '0;
      key_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      keys_ready_q <= 1'b0;
      exp_state_q  <= EXP_IDLE;
      exp_round_q  <= '0;
      exp_cnt_q    <= '0;
      rk_valid_q   <= 1'b0;
      rk_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      cnt_q        <= cnt_d;
      valid_cnt_q  <= valid_cnt_d;
      key_ready_q  <= (state_d == ST_IDLE) || (state_d == ST_DONE);
      busy_q       <= (state_d == ST_LOAD) || (state_d == ST_EXPAND);
      keys_ready_q <= (state_d == ST_DONE);
      exp_state_q  <= (state_d == ST_EXPAND) ? EXP_ADD_RK : EXP_IDLE;
      exp_round_q  <= (state_d == ST_EXPAND) ? round_d : 4'd0;
      exp_cnt_q    <= (state_d == ST_EXPAND) ? cnt_d : 5'd0;
      rk_valid_q   <= rd_en_c;
      rk_err_q     <= rd_en_c && rd_err_c;
    end
  end

  round_key_store #(
    .DEPTH  (NR + 1),
    .WIDTH  (RK_WIDTH),
    .ADDR_W (ROUND_WIDTH)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_en_c),
    .waddr_i (round_q),
    .wdata_i (exp_rk_i),
    .re_i    (rd_en_c),
    .raddr_i (rk_idx_i),
    .rzero_i (rd_err_c),
    .rdata_o (rk_data_o)
  );

  assign key_ready_o  = key_ready_q;
  assign busy_o       = busy_q;
  assign keys_ready_o = keys_ready_q;
  assign exp_state_o  = exp_state_q;
  assign exp_round_o  = exp_round_q;
  assign exp_cnt_o    = exp_cnt_q;
  assign rk_valid_o   = rk_valid_q;
  assign rk_err_o     = rk_err_q;

endmodule
